libhdl_pulse_pacer: RTL

//  Source-side pacer for a toggle-based pulse synchronizer's busy/feedback handshake.

---
 rtl/libhdl_pulse_pacer_if.sv | 35 +++
 rtl/libhdl_pulse_pacer.sv | 105 ++++++++++
 2 files changed

// File: rtl/libhdl_pulse_pacer_if.sv
// Pulse/busy bus between an event source and libhdl_pulse_pacer.
// o_dropCnt exists only when LIBHDL_PULSE_PACER_DROPCNT_EN is defined.
interface libhdl_pulse_pacer_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 i_pulse;
    logic                 i_busy;
    logic                 i_ovfClr;
    logic                 o_pulse;
    logic [CNT_WIDTH-1:0] o_pending;
    logic                 o_idle;
    logic                 o_overflow;
    logic [1:0]           o_dbgState;
`ifdef LIBHDL_PULSE_PACER_DROPCNT_EN
    logic [15:0]          o_dropCnt;
`endif

    // Handshake: each i_pulse-high cycle is one event; the pacer raises
    // o_pulse for one cycle per issue, and only while i_busy was low.
    modport master (
        output i_pulse, i_busy, i_ovfClr,
        input  o_pulse, o_pending, o_idle, o_overflow, o_dbgState
`ifdef LIBHDL_PULSE_PACER_DROPCNT_EN
        , input o_dropCnt
`endif
    );

    modport slave (
        input  i_pulse, i_busy, i_ovfClr,
        output o_pulse, o_pending, o_idle, o_overflow, o_dbgState
`ifdef LIBHDL_PULSE_PACER_DROPCNT_EN
        , output o_dropCnt
`endif
    );
endinterface

// File: rtl/libhdl_pulse_pacer.sv
// Source-side pacer: counts incoming event pulses and re-issues them one at a time
// while the downstream synchronizer is not busy. Optional drop counter: LIBHDL_PULSE_PACER_DROPCNT_EN.
module libhdl_pulse_pacer #(
    parameter int CNT_WIDTH = 8,
    parameter int HOLDOFF   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    libhdl_pulse_pacer_if.slave   s_bus
);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0]        HOLD_INIT = HW'(HOLDOFF - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [HW-1:0]        r_hold;
    logic                 r_pulse;
    logic [CNT_WIDTH-1:0] r_pending;
    logic                 r_overflow;
    logic                 w_issue;
    logic                 w_drop;

    assign w_issue = (r_state == ST_IDLE) && (r_pending != '0) && !s_bus.i_busy;
    // An issue in the same cycle frees a slot, so a full counter only drops without one.
    assign w_drop  = s_bus.i_pulse && !w_issue && (r_pending == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_pulse    <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_pulse <= 1'b1;
                        r_hold  <= HOLD_INIT;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // i_busy is ignored here: downstream needs time to raise it.
                    if (r_hold == '0) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!s_bus.i_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (s_bus.i_pulse && !w_issue && !w_drop) begin
                r_pending <= r_pending + 1'b1;
            end else if (!s_bus.i_pulse && w_issue) begin
                r_pending <= r_pending - 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (s_bus.i_ovfClr) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef LIBHDL_PULSE_PACER_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            if (s_bus.i_ovfClr) begin
                r_drop_cnt <= 16'd1;
            end else if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end else if (s_bus.i_ovfClr) begin
            r_drop_cnt <= '0;
        end
    end

    assign s_bus.o_dropCnt = r_drop_cnt;
`endif

    assign s_bus.o_pulse    = r_pulse;
    assign s_bus.o_pending  = r_pending;
    assign s_bus.o_overflow = r_overflow;
    assign s_bus.o_idle     = (r_state == ST_IDLE) && (r_pending == '0);
    assign s_bus.o_dbgState = r_state;
endmodule
